// File: rtl/ahb_sram_arbiter.sv
// ahb_sram_arbiter
//   Two-master AHB-Lite arbiter in front of the single SRAM slave port.
//   Master 0 is the processor memory port; master 1 is the boot-loader
//   image-load write master. Each master has a one-entry address-phase
//   hold stage. A request that is not accepted by the slave while the
//   master sees HREADY=1 is parked there and is issued later. An
//   uncontended request passes straight through to the slave. The data
//   phase is routed back to the master that owned the accepted address
//   phase.
//
// Ports
//   hclk, hreset            clock, asynchronous active-high reset
//   mN_haddr..mN_hwdata     master N address/control/write data in
//   mN_hrdata/hready/hresp  master N read data, ready and response out
//   s_haddr..s_hwdata       muxed slave address/control/write data out
//   s_hrdata/hready/hresp   slave read data, ready and response in
//   gnt                     one-hot address-phase owner (debug)
module ahb_sram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic              m0_hwrite,
    input  logic              m0_hmastlock,
    input  logic [3:0]        m0_hprot,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic              m1_hwrite,
    input  logic              m1_hmastlock,
    input  logic [3:0]        m1_hprot,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic              s_hwrite,
    output logic              s_hmastlock,
    output logic [3:0]        s_hprot,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp,
    output logic [1:0]        gnt
);

    // Address-phase bundle: {addr, lock, prot, write, burst, size, trans}
    localparam int AP_W = ADDR_W + 14;
    localparam logic [1:0] TR_IDLE = 2'b00;

    logic [AP_W-1:0] live_ap [2];
    logic [AP_W-1:0] hold_ap [2];
    logic [AP_W-1:0] eff_ap  [2];
    logic [AP_W-1:0] s_ap;
    logic [1:0]      hold_vld;
    logic [1:0]      req;
    logic [1:0]      gnt_q;
    logic [1:0]      cur_gnt;
    logic [1:0]      dph_own;
    logic [1:0]      mready;
    logic            last_m1;
    logic            keep;

    assign live_ap[0] = {m0_haddr, m0_hmastlock, m0_hprot, m0_hwrite, m0_hburst, m0_hsize, m0_htrans};
    assign live_ap[1] = {m1_haddr, m1_hmastlock, m1_hprot, m1_hwrite, m1_hburst, m1_hsize, m1_htrans};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            eff_ap[n] = hold_vld[n] ? hold_ap[n] : live_ap[n];
            // NONSEQ/SEQ have trans[1] set; BUSY alone is not a new request
            req[n]    = hold_vld[n] | live_ap[n][1];
        end
    end

    // The current owner keeps the bus while locked or mid-burst (SEQ/BUSY
    // both have trans[0] set), so a burst is never split.
    always_comb begin
        keep = 1'b0;
        if (gnt_q[0])
            keep = eff_ap[0][13] | eff_ap[0][0];
        else if (gnt_q[1])
            keep = eff_ap[1][13] | eff_ap[1][0];
    end

    // Combinational grant gives zero added latency when uncontended. While
    // the slave stalls, the presented address phase must not change.
    always_comb begin
        cur_gnt = 2'b00;
        if (hreset)
            cur_gnt = 2'b00;
        else if (!s_hready || keep)
            cur_gnt = gnt_q;
        else if (req == 2'b11)
            cur_gnt = (FIXED_PRI != 0 || last_m1) ? 2'b01 : 2'b10;
        else
            cur_gnt = req;
    end

    assign s_ap = cur_gnt[0] ? eff_ap[0] : (cur_gnt[1] ? eff_ap[1] : '0);

    assign s_htrans    = s_ap[1:0];
    assign s_hsize     = s_ap[4:2];
    assign s_hburst    = s_ap[7:5];
    assign s_hwrite    = s_ap[8];
    assign s_hprot     = s_ap[12:9];
    assign s_hmastlock = s_ap[13];
    assign s_haddr     = s_ap[AP_W-1:14];
    assign gnt         = cur_gnt;

    always_comb begin
        for (int n = 0; n < 2; n++)
            mready[n] = dph_own[n] ? s_hready : ~hold_vld[n];
    end

    assign m0_hready = mready[0];
    assign m1_hready = mready[1];
    assign m0_hrdata = dph_own[0] ? s_hrdata : '0;
    assign m1_hrdata = dph_own[1] ? s_hrdata : '0;
    assign m0_hresp  = dph_own[0] & s_hresp;
    assign m1_hresp  = dph_own[1] & s_hresp;
    assign s_hwdata  = dph_own[0] ? m0_hwdata : (dph_own[1] ? m1_hwdata : '0);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            gnt_q      <= 2'b00;
            dph_own    <= 2'b00;
            hold_vld   <= 2'b00;
            last_m1    <= 1'b1;
            hold_ap[0] <= '0;
            hold_ap[1] <= '0;
        end else begin
            gnt_q <= cur_gnt;
            if (s_hready) begin
                // An accepted IDLE leaves no data phase to route back
                if (s_ap[1:0] != TR_IDLE) begin
                    dph_own <= cur_gnt;
                    last_m1 <= cur_gnt[1];
                end else begin
                    dph_own <= 2'b00;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (hold_vld[n]) begin
                    if (cur_gnt[n] && s_hready)
                        hold_vld[n] <= 1'b0;
                end else if (live_ap[n][1] && mready[n] && !(cur_gnt[n] && s_hready)) begin
                    // Master believes its address phase completed; park it
                    hold_vld[n] <= 1'b1;
                    hold_ap[n]  <= live_ap[n];
                end
            end
        end
    end

endmodule
